// File: rtl/gray_ptr_sync_multi.sv
// gray_ptr_sync_multi: brings CHANNELS gray pointers into the sync_clk
// domain through a STAGES-deep flop chain, then registers the binary
// pointer, its per-cycle advance and a change pulse.
// Optional gray-code checker: define GRAY_PTR_SYNC_CHECK_EN.
// Ports:
//   sync_clk, sync_rst  clock, synchronous active-high reset
//   gray_ptr_in         async gray pointers, channel c at [c*W +: W]
//   err_clear           clears gray_err / err_count (checker builds)
//   sync_gray_ptr       last synchroniser stage (gray)
//   sync_bin_ptr        registered binary pointer
//   ptr_advance         binary advance since previous cycle, mod 2^W
//   ptr_changed         one-cycle pulse per binary change
//   gray_err            sticky per-channel gray violation
//   err_count           saturating count of violating cycles
module gray_ptr_sync_multi #(
    parameter int ADDRESS_BITS = 4,
    parameter int STAGES       = 2,
    parameter int CHANNELS     = 1
) (
    input  logic                                  sync_clk,
    input  logic                                  sync_rst,
    input  logic [CHANNELS*(ADDRESS_BITS+1)-1:0]  gray_ptr_in,
    input  logic                                  err_clear,
    output logic [CHANNELS*(ADDRESS_BITS+1)-1:0]  sync_gray_ptr,
    output logic [CHANNELS*(ADDRESS_BITS+1)-1:0]  sync_bin_ptr,
    output logic [CHANNELS*(ADDRESS_BITS+1)-1:0]  ptr_advance,
    output logic [CHANNELS-1:0]                   ptr_changed,
    output logic [CHANNELS-1:0]                   gray_err,
    output logic [7:0]                            err_count
);

    localparam int W = ADDRESS_BITS + 1;
    localparam int N = CHANNELS * W;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync_multi: STAGES must be in 2..4");
    end

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("gray_ptr_sync_multi: CHANNELS must be in 1..8");
    end

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b        = '0;
        b[W-1]   = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Synchroniser chain; stage 0 is the first (metastable) flop.
    logic [N-1:0] chain_q [STAGES];
    logic [N-1:0] last;

    always_ff @(posedge sync_clk) begin
        if (sync_rst) begin
            for (int s = 0; s < STAGES; s++) begin
                chain_q[s] <= '0;
            end
        end else begin
            chain_q[0] <= gray_ptr_in;
            for (int s = 1; s < STAGES; s++) begin
                chain_q[s] <= chain_q[s-1];
            end
        end
    end

    assign last          = chain_q[STAGES-1];
    assign sync_gray_ptr = last;

    // bin_q doubles as the previous binary pointer for advance/change.
    logic [N-1:0]        bin_d;
    logic [N-1:0]        adv_d;
    logic [CHANNELS-1:0] chg_d;
    logic [N-1:0]        bin_q;
    logic [N-1:0]        adv_q;
    logic [CHANNELS-1:0] chg_q;

    always_comb begin
        bin_d = '0;
        adv_d = '0;
        chg_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bin_d[c*W +: W] = gray2bin(last[c*W +: W]);
            adv_d[c*W +: W] = bin_d[c*W +: W] - bin_q[c*W +: W];
            chg_d[c]        = bin_d[c*W +: W] != bin_q[c*W +: W];
        end
    end

    always_ff @(posedge sync_clk) begin
        if (sync_rst) begin
            bin_q <= '0;
            adv_q <= '0;
            chg_q <= '0;
        end else begin
            bin_q <= bin_d;
            adv_q <= adv_d;
            chg_q <= chg_d;
        end
    end

    assign sync_bin_ptr = bin_q;
    assign ptr_advance  = adv_q;
    assign ptr_changed  = chg_q;

`ifdef GRAY_PTR_SYNC_CHECK_EN
    logic [N-1:0]        prev_gray_q;
    logic [CHANNELS-1:0] viol;
    logic [CHANNELS-1:0] err_q;
    logic [7:0]          cnt_q;
    logic [W-1:0]        diff;

    // More than one bit set <=> clearing the lowest set bit leaves a bit.
    always_comb begin
        viol = '0;
        diff = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            diff    = last[c*W +: W] ^ prev_gray_q[c*W +: W];
            viol[c] = (diff & (diff - W'(1))) != '0;
        end
    end

    always_ff @(posedge sync_clk) begin
        if (sync_rst) begin
            prev_gray_q <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
        end else begin
            prev_gray_q <= last;
            if (err_clear) begin
                // A violation seen on the clearing edge survives the clear.
                err_q <= viol;
                cnt_q <= {7'd0, |viol};
            end else begin
                err_q <= err_q | viol;
                if ((|viol) && (cnt_q != 8'hFF)) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign gray_err  = err_q;
    assign err_count = cnt_q;
`else
    logic unused_err_clear;

    assign unused_err_clear = err_clear;
    assign gray_err         = '0;
    assign err_count        = 8'd0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_multi.sv
// tb_gray_ptr_sync_multi: randomized bench for gray_ptr_sync_multi with
// a history-based reference model (ADDRESS_BITS=4, STAGES=2, CHANNELS=2).
module tb_gray_ptr_sync_multi;

    localparam int AB  = 4;
    localparam int STG = 2;
    localparam int CH  = 2;
    localparam int W   = AB + 1;
    localparam int N   = CH * W;
`ifdef GRAY_PTR_SYNC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [N-1:0]  gin = '0;
    logic [N-1:0]  s_gray;
    logic [N-1:0]  s_bin;
    logic [N-1:0]  s_adv;
    logic [CH-1:0] s_chg;
    logic [CH-1:0] s_err;
    logic [7:0]    s_cnt;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gray_ptr_sync_multi #(
        .ADDRESS_BITS (AB),
        .STAGES       (STG),
        .CHANNELS     (CH)
    ) dut (
        .sync_clk      (clk),
        .sync_rst      (rst),
        .gray_ptr_in   (gin),
        .err_clear     (clr),
        .sync_gray_ptr (s_gray),
        .sync_bin_ptr  (s_bin),
        .ptr_advance   (s_adv),
        .ptr_changed   (s_chg),
        .gray_err      (s_err),
        .err_count     (s_cnt)
    );

    // Binary value of a gray code: XOR of all right shifts of g.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int s = 0; s < W; s++) b ^= g >> s;
        return b;
    endfunction

    // ---------------- reference model ----------------
    logic [N-1:0]  e_gray = '0;
    logic [N-1:0]  e_gray_prev = '0;
    logic [N-1:0]  e_bin = '0;
    logic [N-1:0]  e_adv = '0;
    logic [CH-1:0] e_chg = '0;
    logic [CH-1:0] e_err = '0;
    logic [7:0]    e_cnt = '0;
    logic [N-1:0]  in_q[$] = '{'0, '0, '0, '0};
    bit            rst_q[$] = '{1'b1, 1'b1, 1'b1, 1'b1};

    always @(posedge clk) begin : model
        logic [N-1:0]  ng;
        logic [N-1:0]  gpp;
        logic [W-1:0]  b;
        logic [W-1:0]  bp;
        logic [CH-1:0] v;
        bit            hit;
        in_q.push_front(gin);
        rst_q.push_front(rst);
        while (in_q.size() > STG + 2) in_q.pop_back();
        while (rst_q.size() > STG + 2) rst_q.pop_back();
        // gray output = input from STG-1 edges ago unless a reset hit the window
        hit = 1'b0;
        for (int i = 0; i < STG; i++) hit |= rst_q[i];
        ng  = hit ? '0 : in_q[STG-1];
        gpp = rst_q[1] ? '0 : e_gray_prev;
        v   = '0;
        if (rst) begin
            e_bin = '0; e_adv = '0; e_chg = '0;
            e_err = '0; e_cnt = '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                b  = g2b(e_gray[c*W +: W]);
                bp = e_bin[c*W +: W];
                e_bin[c*W +: W] = b;
                e_adv[c*W +: W] = W'((32 + int'(b) - int'(bp)) % 32);
                e_chg[c] = (b != bp);
                v[c] = $countones(e_gray[c*W +: W] ^ gpp[c*W +: W]) > 1;
            end
            if (CHK) begin
                if (clr) begin
                    e_err = v;
                    e_cnt = (v != '0) ? 8'd1 : 8'd0;
                end else begin
                    e_err = e_err | v;
                    if (v != '0 && e_cnt < 8'd255) e_cnt = e_cnt + 8'd1;
                end
            end
        end
        e_gray_prev = e_gray;
        e_gray      = ng;
    end

    function automatic logic [41:0] dut_vec();
        return {s_gray, s_bin, s_adv, s_chg, s_err, s_cnt};
    endfunction

    function automatic logic [41:0] mdl_vec();
        return {e_gray, e_bin, e_adv, e_chg, e_err, e_cnt};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; clr = 1'b0; gin = '0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            gin = N'($urandom);
            clr = 1'($urandom);
            cyc();
            n_run++;
            if (dut_vec() !== 42'd0) begin
                n_fail++;
                $display("FAIL reset_zero cyc=%0d got=%h want=0", i, dut_vec());
            end
        end
        gin = '0; clr = 1'b0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_run++;
            if (dut_vec() !== 42'd0 || mdl_vec() !== 42'd0) begin
                n_fail++;
                $display("FAIL reset_idle got=%h want=0", dut_vec());
            end
        end
    endtask

    task automatic test_single_step();
        gin = 10'b00000_00001;
        cyc();
        n_run++;
        if (s_gray !== 10'd0) begin
            n_fail++;
            $display("FAIL step_edge1 gray=%h want=0", s_gray);
        end
        cyc();
        n_run++;
        if (s_gray !== 10'd1 || s_bin !== 10'd0) begin
            n_fail++;
            $display("FAIL step_edge2 gray=%h bin=%h want 1/0", s_gray, s_bin);
        end
        cyc();
        n_run++;
        if (s_bin !== 10'd1 || s_adv !== 10'd1 || s_chg !== 2'b01
            || s_err !== 2'b00) begin
            n_fail++;
            $display("FAIL step_edge3 bin=%h adv=%h chg=%b err=%b want 1/1/01/00",
                     s_bin, s_adv, s_chg, s_err);
        end
        cyc();
        n_run++;
        if (s_chg !== 2'b00 || s_adv !== 10'd0 || s_bin !== 10'd1) begin
            n_fail++;
            $display("FAIL step_pulse chg=%b adv=%h bin=%h want 00/0/1",
                     s_chg, s_adv, s_bin);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] b0;
        logic [W-1:0] g;
        logic [W-1:0] last_b1;
        bit           wrapped;
        apply_reset();
        b0 = '0; last_b1 = '0; wrapped = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            g = W'(i % 32) ^ (W'(i % 32) >> 1);
            if ($urandom_range(0, 1) == 1) b0 = b0 + 1'b1;
            gin = {g, b0 ^ (b0 >> 1)};
            for (int k = 0; k < 3; k++) begin
                cyc();
                n_run++;
                if (dut_vec() !== mdl_vec()) begin
                    n_fail++;
                    $display("FAIL wrap_model got=%h want=%h", dut_vec(), mdl_vec());
                end
                if (last_b1 == 5'd31 && s_bin[9:5] == 5'd0) begin
                    wrapped = 1'b1;
                    n_run++;
                    if (s_adv[9:5] !== 5'd1) begin
                        n_fail++;
                        $display("FAIL wrap_adv got=%h want=1", s_adv[9:5]);
                    end
                end
                last_b1 = s_bin[9:5];
            end
        end
        cyc();
        n_run++;
        if (!wrapped || s_err !== 2'b00 || s_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_clean wrapped=%0d err=%b cnt=%0d want 1/00/0",
                     wrapped, s_err, s_cnt);
        end
    endtask

    task automatic test_violation();
        apply_reset();
        gin = 10'b00000_00011;
        cyc(); cyc(); cyc();
        n_run++;
        if (s_err !== (CHK ? 2'b01 : 2'b00) || s_cnt !== (CHK ? 8'd1 : 8'd0)
            || s_adv[4:0] !== 5'd2 || s_bin[4:0] !== 5'd2) begin
            n_fail++;
            $display("FAIL viol_detect err=%b cnt=%0d adv=%0d bin=%0d",
                     s_err, s_cnt, s_adv[4:0], s_bin[4:0]);
        end
        cyc(); cyc(); cyc();
        n_run++;
        if (s_err !== (CHK ? 2'b01 : 2'b00) || s_cnt !== (CHK ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("FAIL viol_sticky err=%b cnt=%0d", s_err, s_cnt);
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_run++;
        if (s_err !== 2'b00 || s_cnt !== 8'd0 || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL viol_clear err=%b cnt=%0d want 00/0", s_err, s_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] p;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            do p = W'($urandom_range(1, 31)); while ($countones(p) < 2);
            gin[4:0] = gin[4:0] ^ p;
            cyc();
            n_run++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL sat_model got=%h want=%h", dut_vec(), mdl_vec());
            end
        end
        cyc(); cyc(); cyc(); cyc();
        n_run++;
        if (s_cnt !== (CHK ? 8'd255 : 8'd0)) begin
            n_fail++;
            $display("FAIL sat_count got=%0d want=%0d", s_cnt, CHK ? 255 : 0);
        end
        gin[9:5] = gin[9:5] ^ 5'b00101;
        cyc(); cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_run++;
        if (s_err !== (CHK ? 2'b10 : 2'b00) || s_cnt !== (CHK ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("FAIL clr_collide err=%b cnt=%0d", s_err, s_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] b [CH];
        int           r;
        apply_reset();
        for (int c = 0; c < CH; c++) b[c] = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) begin
                r = $urandom_range(0, 9);
                if (r == 6 || r == 7) b[c] = b[c] + 1'b1;
                else if (r == 8) b[c] = b[c] + W'($urandom_range(2, 5));
                else if (r == 9) b[c] = W'($urandom);
                gin[c*W +: W] = b[c] ^ (b[c] >> 1);
            end
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 63) == 0);
            cyc();
            n_run++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL rand_model cyc=%0d got=%h want=%h",
                         i, dut_vec(), mdl_vec());
            end
        end
        rst = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_wrap();
        test_violation();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
